// File: rtl/mult_div_sequencer.sv
// Control sequencer for the multiply/divide datapath: loads operands, steps radix-4 Booth
// multiply or non-restoring divide once per clock, and ends each command with a DONE strobe.
module mult_div_sequencer #(
  parameter int MPY_STEPS = 13,
  parameter int DIV_STEPS = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       op_div,
  input  logic [2:0] mrb,
  input  logic       rem_sgn,
  input  logic       divz,
  output logic       busy,
  output logic       load_en,
  output logic       shift_en,
  output logic [2:0] msel,
  output logic       div_sub,
  output logic       q_bit,
  output logic       div_restore,
  output logic [4:0] step,
  output logic       done,
  output logic       dz_err
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MPY_RUN,
    DIV_RUN,
    DIV_FIX,
    FIN
  } state_t;

  localparam logic [4:0] MPY_LAST = 5'(MPY_STEPS - 1);
  localparam logic [4:0] DIV_LAST = 5'(DIV_STEPS - 1);

  state_t state;
  state_t next_state;
  logic   op_div_q;
  logic   dz_q;

  // State, iteration counter and the latched command attributes
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      step     <= 5'd0;
      op_div_q <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && start)
        op_div_q <= op_div;
      step <= ((state == MPY_RUN || state == DIV_RUN) && next_state == state)
              ? step + 5'd1 : 5'd0;
      if (state == LOAD)
        dz_q <= op_div_q & divz;
      else if (state == FIN)
        dz_q <= 1'b0;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD;
      LOAD: begin
        if (op_div_q && divz) next_state = FIN;
        else if (op_div_q)    next_state = DIV_RUN;
        else                  next_state = MPY_RUN;
      end
      MPY_RUN: if (step == MPY_LAST) next_state = FIN;
      DIV_RUN: if (step == DIV_LAST) next_state = DIV_FIX;
      DIV_FIX: next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath strobes; Booth and divide selects are forced low outside the run states
  always_comb begin
    busy        = (state != IDLE);
    load_en     = (state == LOAD);
    shift_en    = 1'b0;
    msel        = 3'b000;
    div_sub     = 1'b0;
    q_bit       = 1'b0;
    div_restore = 1'b0;
    done        = (state == FIN);
    dz_err      = dz_q | (state == LOAD && op_div_q && divz);
    case (state)
      MPY_RUN: begin
        shift_en = 1'b1;
        case (mrb)
          3'b001, 3'b010: msel = 3'b001;
          3'b011:         msel = 3'b010;
          3'b100:         msel = 3'b110;
          3'b101, 3'b110: msel = 3'b101;
          default:        msel = 3'b000;
        endcase
      end
      DIV_RUN: begin
        shift_en = 1'b1;
        div_sub  = (step == 5'd0) ? 1'b1 : ~rem_sgn;
        q_bit    = ~rem_sgn;
      end
      DIV_FIX: div_restore = rem_sgn;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: per-cycle expectations for multiply, divide,
// divide-by-zero, mid-operation reset and START while busy.
module tb_mult_div_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, op_div, rem_sgn, divz;
  logic [2:0] mrb;
  logic       busy, load_en, shift_en, div_sub, q_bit, div_restore, done, dz_err;
  logic [2:0] msel;
  logic [4:0] step;

  int vectors     = 0;
  int miscompares = 0;
  int doneCount   = 0;

  // Hand-derived Booth select tables
  logic [2:0] cycMrb [3] = '{3'b100, 3'b101, 3'b000};
  logic [2:0] cycMsel[3] = '{3'b110, 3'b101, 3'b000};
  logic [2:0] allMsel[8] = '{3'b000, 3'b001, 3'b001, 3'b010,
                             3'b110, 3'b101, 3'b101, 3'b000};

  mult_div_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op_div(op_div), .mrb(mrb),
    .rem_sgn(rem_sgn), .divz(divz), .busy(busy), .load_en(load_en),
    .shift_en(shift_en), .msel(msel), .div_sub(div_sub), .q_bit(q_bit),
    .div_restore(div_restore), .step(step), .done(done), .dz_err(dz_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // n counts edges after the START edge; pat 0 = MRB 011, 1 = 100/101/000 cycle,
  // 2 = all eight MRB codes; divide always toggles REM_SGN starting at 0
  task automatic applyStimulus(input logic op, input logic dz, input int pat,
                               input bit pokeStart, input string name);
    int steps, doneN, k;
    logic remNow;
    logic [2:0] expMsel;
    logic expSub, expQ, isRun;
    steps = dz ? 0 : (op ? 26 : 13);
    doneN = op ? (dz ? 1 : 28) : 14;
    start  = 1'b1;
    op_div = op;
    for (int n = 0; n <= doneN + 1; n++) begin
      tick();
      k      = n - 1;
      isRun  = (n >= 1 && n <= steps);
      start  = pokeStart && n >= 1 && n <= doneN;
      op_div = pokeStart ? ~op : op;
      divz   = (n == 0) ? dz : 1'b0;
      mrb    = 3'b011;
      rem_sgn = 1'b1;
      if (isRun && !op) begin
        if (pat == 1)      mrb = cycMrb[k % 3];
        else if (pat == 2) mrb = 3'(k % 8);
      end
      if (isRun && op) rem_sgn = (k % 2 == 1);
      remNow = rem_sgn;
      #1;
      expMsel = 3'b000;
      if (isRun && !op) begin
        if (pat == 0)      expMsel = 3'b010;
        else if (pat == 1) expMsel = cycMsel[k % 3];
        else               expMsel = allMsel[k % 8];
      end
      expSub = isRun && op && (k == 0 || !remNow);
      expQ   = isRun && op && !remNow;
      if (done) doneCount++;
      checkOutput($sformatf("%s n=%0d load_en", name, n), 8'(load_en), 8'(n == 0));
      checkOutput($sformatf("%s n=%0d busy", name, n), 8'(busy), 8'(n <= doneN));
      checkOutput($sformatf("%s n=%0d shift_en", name, n), 8'(shift_en), 8'(isRun));
      checkOutput($sformatf("%s n=%0d msel", name, n), 8'(msel), 8'(expMsel));
      checkOutput($sformatf("%s n=%0d div_sub", name, n), 8'(div_sub), 8'(expSub));
      checkOutput($sformatf("%s n=%0d q_bit", name, n), 8'(q_bit), 8'(expQ));
      checkOutput($sformatf("%s n=%0d div_restore", name, n), 8'(div_restore),
                  8'(op && !dz && n == 27));
      checkOutput($sformatf("%s n=%0d done", name, n), 8'(done), 8'(n == doneN));
      if (isRun)
        checkOutput($sformatf("%s n=%0d step", name, n), 8'(step), 8'(k));
      if (n == doneN)
        checkOutput($sformatf("%s dz_err with done", name), 8'(dz_err), 8'(dz));
      if (n == doneN + 1)
        checkOutput($sformatf("%s dz_err after done", name), 8'(dz_err), 8'd0);
    end
  endtask

  initial begin
    int seen;
    reset   = 1'b1;
    start   = 1'b1;
    op_div  = 1'b1;
    mrb     = 3'b000;
    rem_sgn = 1'b0;
    divz    = 1'b0;
    repeat (3) tick();
    checkOutput("reset busy", 8'(busy), 8'd0);
    checkOutput("reset load_en", 8'(load_en), 8'd0);
    checkOutput("reset shift_en", 8'(shift_en), 8'd0);
    checkOutput("reset done", 8'(done), 8'd0);
    checkOutput("reset step", 8'(step), 8'd0);
    checkOutput("reset dz_err", 8'(dz_err), 8'd0);

    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 0, 1'b0, "divz");
    applyStimulus(1'b0, 1'b0, 0, 1'b0, "mpy011");
    applyStimulus(1'b0, 1'b0, 1, 1'b0, "mpycyc");
    applyStimulus(1'b0, 1'b0, 2, 1'b0, "mpyall");
    applyStimulus(1'b1, 1'b0, 0, 1'b0, "div");
    checkOutput("done pulse count", 8'(doneCount), 8'd5);

    // Reset while dividing at step 7
    start  = 1'b1;
    op_div = 1'b1;
    for (int n = 0; n <= 8; n++) begin
      tick();
      start   = 1'b0;
      divz    = 1'b0;
      rem_sgn = 1'b0;
      #1;
    end
    checkOutput("midrst step before", 8'(step), 8'd7);
    reset   = 1'b1;
    rem_sgn = 1'b1;
    mrb     = 3'b011;
    tick();
    checkOutput("midrst busy", 8'(busy), 8'd0);
    checkOutput("midrst shift_en", 8'(shift_en), 8'd0);
    checkOutput("midrst q_bit", 8'(q_bit), 8'd0);
    checkOutput("midrst step", 8'(step), 8'd0);
    checkOutput("midrst done", 8'(done), 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("postrst busy %0d", i), 8'(busy), 8'd0);
      checkOutput($sformatf("postrst done %0d", i), 8'(done), 8'd0);
    end

    // START held through a multiply (with OP_DIV flipped) must not disturb or queue
    doneCount = 0;
    applyStimulus(1'b0, 1'b0, 0, 1'b1, "mpypoke");
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) seen++;
      checkOutput($sformatf("poke idle busy %0d", i), 8'(busy), 8'd0);
    end
    checkOutput("poke done count", 8'(doneCount + seen), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
